// File: rtl/mul_sequencer.sv
// Shift-add multiply engine and register-file write sequencer for MUL/UMULL/SMULL.
// Optional MUL_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier is zero.
//
// state | meaning
// IDLE  | waiting for Start, operands latched on acceptance
// CALC  | one shift-add iteration per cycle
// WLO   | Done pulse, low-word write strobe
// WHI   | high-word write strobe (long multiplies only)
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             IsLongMul,
    input  logic             IsSigned,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             WrLo,
    output logic             WrHi,
    output logic [1:0]       MulState
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WLO  = 2'd2,
        WHI  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [2*WIDTH-1:0] mcand, acc, acc_sum, product;
    logic [WIDTH-1:0]   mplier, a_abs, b_abs;
    logic [CW-1:0]      cnt;
    logic               neg, is_long, signed_op, calc_last;

    // Signed operation is done as magnitude multiply plus a final negation.
    always_comb begin
        signed_op = IsSigned & IsLongMul;
        a_abs     = (signed_op && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        b_abs     = (signed_op && SrcB[WIDTH-1]) ? -SrcB : SrcB;
        acc_sum   = acc + (mplier[0] ? mcand : '0);
        product   = neg ? -acc_sum : acc_sum;
`ifdef MUL_EARLY_TERM_EN
        calc_last = (cnt == LAST) || (mplier[WIDTH-1:1] == '0);
`else
        calc_last = (cnt == LAST);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b1;
        Done       = 1'b0;
        WrLo       = 1'b0;
        WrHi       = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) state_next = CALC;
            end
            CALC: if (calc_last) state_next = WLO;
            WLO: begin
                Done       = 1'b1;
                WrLo       = 1'b1;
                state_next = is_long ? WHI : IDLE;
            end
            WHI: begin
                WrHi       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            is_long  <= 1'b0;
            ResultLo <= '0;
            ResultHi <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    mcand   <= {{WIDTH{1'b0}}, a_abs};
                    mplier  <= b_abs;
                    neg     <= signed_op & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    is_long <= IsLongMul;
                    acc     <= '0;
                    cnt     <= '0;
                end
                CALC: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (calc_last) {ResultHi, ResultLo} <= product;
                end
                default: ;
            endcase
        end
    end

    assign MulState = state;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed cases from the test plan plus random operations
// compared against a plain-arithmetic product and latency model.
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset, Start, IsLongMul, IsSigned;
    logic [31:0] SrcA, SrcB;
    logic        Busy, Done, WrLo, WrHi;
    logic [31:0] ResultLo, ResultHi;
    logic [1:0]  MulState;

    int errors = 0;
    int checks = 0;

    int          o_lo_cyc, o_hi_cyc, o_idle_cyc;
    logic [31:0] o_lo, o_hi;
    logic        o_bad;

    mul_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Start(Start), .IsLongMul(IsLongMul), .IsSigned(IsSigned),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .ResultLo(ResultLo),
        .ResultHi(ResultHi), .WrLo(WrLo), .WrHi(WrHi), .MulState(MulState)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_product(input logic lng, input logic sgn,
                                                  input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (lng && sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Cycle (counting the Start edge as 0) at which WrLo is expected.
    function automatic int model_lo_cyc(input logic lng, input logic sgn, input logic [31:0] b);
        logic [31:0] m;
        int n;
`ifdef MUL_EARLY_TERM_EN
        m = (lng && sgn && b[31]) ? (32'd0 - b) : b;
        n = 0;
        while (m != 0) begin
            n++;
            m = m >> 1;
        end
        if (n == 0) n = 1;
`else
        n = 32;
`endif
        return n + 1;
    endfunction

    // Issues one operation from an idle cycle and records what the DUT does until Busy drops.
    task automatic do_op(input logic lng, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int repulse_cyc);
        IsLongMul = lng; IsSigned = sgn; SrcA = a; SrcB = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        o_lo_cyc = -1; o_hi_cyc = -1; o_idle_cyc = -1; o_lo = 'x; o_hi = 'x; o_bad = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (WrLo) begin o_lo_cyc = c; o_lo = ResultLo; end
            if (WrHi) begin o_hi_cyc = c; o_hi = ResultHi; end
            if ((WrLo && WrHi) || (Done !== WrLo)) o_bad = 1'b1;
            if (!Busy) begin o_idle_cyc = c; break; end
            Start = (c == repulse_cyc);
            if (c == repulse_cyc) begin SrcA = '1; SrcB = '1; end
            @(posedge clk); #1;
        end
        Start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; Start = 1'b1; IsLongMul = 1'b1; IsSigned = 1'b0; SrcA = 32'd3; SrcB = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        if (MulState !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", MulState); end
        checks++;
        if ({Busy, Done, WrLo, WrHi} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {Busy, Done, WrLo, WrHi}); end
        checks++;
        if ({ResultHi, ResultLo} !== 64'd0) begin errors++; $display("FAIL reset_results got %h exp 0", {ResultHi, ResultLo}); end
        checks++;
        reset = 1'b0; Start = 1'b0;
        @(posedge clk); #1;
        if (MulState !== 2'd0 || Busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored got state %0d busy %b exp 0 0", MulState, Busy); end
        checks++;
    endtask

    task automatic test_umull_max;
        do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        if (o_lo_cyc != 33 || o_lo !== 32'h1) begin errors++; $display("FAIL umull_max_lo got cyc %0d val %h exp cyc 33 val 00000001", o_lo_cyc, o_lo); end
        checks++;
        if (o_hi_cyc != 34 || o_hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umull_max_hi got cyc %0d val %h exp cyc 34 val fffffffe", o_hi_cyc, o_hi); end
        checks++;
        if (o_idle_cyc != 35 || o_bad) begin errors++; $display("FAIL umull_max_idle got cyc %0d bad %b exp cyc 35 bad 0", o_idle_cyc, o_bad); end
        checks++;
    endtask

    task automatic test_smull;
        do_op(1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 0);
        if ({o_hi, o_lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL smull_neg2x3 got %h_%h exp ffffffff_fffffffa", o_hi, o_lo); end
        checks++;
        do_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        if ({o_hi, o_lo} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL smull_minsq got %h_%h exp 40000000_00000000", o_hi, o_lo); end
        checks++;
        if (o_hi_cyc != o_lo_cyc + 1 || o_bad) begin errors++; $display("FAIL smull_minsq_seq got lo %0d hi %0d bad %b", o_lo_cyc, o_hi_cyc, o_bad); end
        checks++;
    endtask

    task automatic test_mul;
        int lo_exp;
        lo_exp = model_lo_cyc(1'b0, 1'b0, 32'd6);
        do_op(1'b0, 1'b1, 32'd7, 32'd6, 0);
        if (o_lo_cyc != lo_exp || o_lo !== 32'd42) begin errors++; $display("FAIL mul_7x6 got cyc %0d val %0d exp cyc %0d val 42", o_lo_cyc, o_lo, lo_exp); end
        checks++;
        if (o_hi_cyc != -1 || o_idle_cyc != lo_exp + 1) begin errors++; $display("FAIL mul_no_hi got hi %0d idle %0d exp hi -1 idle %0d", o_hi_cyc, o_idle_cyc, lo_exp + 1); end
        checks++;
    endtask

    task automatic test_ignore_start;
        do_op(1'b1, 1'b0, 32'd5, 32'd9, 5);
        if (o_lo !== 32'd45 || o_hi !== 32'd0) begin errors++; $display("FAIL ignore_start got %h_%h exp 00000000_0000002d", o_hi, o_lo); end
        checks++;
        if (o_lo_cyc != model_lo_cyc(1'b1, 1'b0, 32'd9)) begin errors++; $display("FAIL ignore_start_lat got %0d exp %0d", o_lo_cyc, model_lo_cyc(1'b1, 1'b0, 32'd9)); end
        checks++;
    endtask

    task automatic test_reset_mid;
        int rc;
        logic strobe_seen;
`ifdef MUL_EARLY_TERM_EN
        rc = 3;
`else
        rc = 10;
`endif
        IsLongMul = 1'b1; IsSigned = 1'b0; SrcA = 32'd5; SrcB = 32'd9; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        strobe_seen = 1'b0;
        for (int c = 1; c < rc; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        if (MulState !== 2'd0 || Busy !== 1'b0) begin errors++; $display("FAIL reset_mid_state got %0d busy %b exp 0 0", MulState, Busy); end
        checks++;
        if ({ResultHi, ResultLo} !== 64'd0) begin errors++; $display("FAIL reset_mid_results got %h exp 0", {ResultHi, ResultLo}); end
        checks++;
        for (int c = 0; c < 40; c++) begin
            if (WrLo || WrHi || Busy) strobe_seen = 1'b1;
            @(posedge clk); #1;
        end
        if (strobe_seen !== 1'b0) begin errors++; $display("FAIL reset_mid_no_write got activity exp none"); end
        checks++;
        do_op(1'b1, 1'b0, 32'd5, 32'd9, 0);
        if ({o_hi, o_lo} !== 64'd45 || o_hi_cyc != o_lo_cyc + 1) begin errors++; $display("FAIL reset_mid_fresh got %h_%h hi %0d lo %0d exp 45", o_hi, o_lo, o_hi_cyc, o_lo_cyc); end
        checks++;
    endtask

    task automatic test_early_term;
        int lo_exp;
`ifdef MUL_EARLY_TERM_EN
        lo_exp = 2;
`else
        lo_exp = 33;
`endif
        do_op(1'b1, 1'b0, 32'h1234_5678, 32'd1, 0);
        if (o_lo_cyc != lo_exp || o_lo !== 32'h1234_5678 || o_hi !== 32'd0) begin
            errors++; $display("FAIL early_term got cyc %0d %h_%h exp cyc %0d 00000000_12345678", o_lo_cyc, o_hi, o_lo, lo_exp);
        end
        checks++;
    endtask

    // Consecutive calls restart in the first idle cycle, so these also cover back-to-back issue.
    task automatic test_back_to_back_random;
        logic        lng, sgn;
        logic [31:0] a, b;
        logic [63:0] p;
        int          lo_exp;
        for (int i = 0; i < 24; i++) begin
            lng = 1'($urandom);
            sgn = 1'($urandom);
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i % 4 == 0) b = -b;
            p = model_product(lng, sgn, a, b);
            lo_exp = model_lo_cyc(lng, sgn, b);
            do_op(lng, sgn, a, b, 0);
            if (o_lo !== p[31:0] || (lng && o_hi !== p[63:32])) begin
                errors++; $display("FAIL rand_result[%0d] long %b sgn %b a %h b %h got %h_%h exp %h", i, lng, sgn, a, b, o_hi, o_lo, p);
            end
            checks++;
            if (o_lo_cyc != lo_exp || o_hi_cyc != (lng ? lo_exp + 1 : -1)
                || o_idle_cyc != lo_exp + (lng ? 2 : 1) || o_bad) begin
                errors++; $display("FAIL rand_timing[%0d] got lo %0d hi %0d idle %0d bad %b exp lo %0d", i, o_lo_cyc, o_hi_cyc, o_idle_cyc, o_bad, lo_exp);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset;
        test_umull_max;
        test_smull;
        test_mul;
        test_ignore_start;
        test_reset_mid;
        test_early_term;
        test_back_to_back_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle shift-add multiply engine and sequencer for the multi-cycle ARM core. It executes MUL, UMULL and SMULL on the decoder's multiply path. It raises Busy while the main FSM holds in its multiply state. It then drives the register-file write strobes for the low word and, for long multiplies, the high word on the following cycle, because the register file has one write port.

## Interface
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- Start  in  1  one-cycle request from the decoder when it enters the multiply state (opMul asserted).
- IsLongMul  in  1  1 = UMULL/SMULL (two result words), 0 = MUL (low word only).
- IsSigned  in  1  1 = SMULL (Instr[22]); ignored when IsLongMul=0.
- SrcA  in  WIDTH  multiplicand (Rn/Rm operand from datapath).
- SrcB  in  WIDTH  multiplier.
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse when ResultLo first becomes valid.
- ResultLo  out  WIDTH  product bits [WIDTH-1:0].
- ResultHi  out  WIDTH  product bits [2*WIDTH-1:WIDTH].
- WrLo  out  1  register-file write strobe for the low word (RdLo / Rd).
- WrHi  out  1  register-file write strobe for the high word (RdHi).
- MulState  out  2  current FSM state, for debug.

## Operation
- States: IDLE=0, CALC=1, WLO=2, WHI=3.
- IDLE
  - Busy=0.
  - When Start=1, latch the operands, operation type and sign information, then go to CALC.
  - For signed operation, latch |SrcA| and |SrcB| and store neg = SrcA[W-1] ^ SrcB[W-1].
  - Otherwise latch the raw operands with neg=0.
  - Clear the 2W-bit accumulator and the iteration counter.
- CALC, one iteration per cycle:
  - If multiplier[0]=1, add the 2W-bit multiplicand register to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
  - After WIDTH iterations, go to WLO.
  - On the CALC→WLO transition, load {ResultHi, ResultLo} with the accumulator, or with its two's-complement negation when neg=1.
- WLO
  - Done=1 and WrLo=1.
  - If IsLongMul, go to WHI; otherwise go to IDLE.
- WHI
  - WrHi=1, then go to IDLE.
- Arithmetic:
  - Unsigned operation gives the exact 2W-bit product.
  - Signed operation gives the exact two's-complement 2W-bit product, including the (-2^(W-1))² case.
  - MUL returns the low W bits; these are identical for signed and unsigned operands.
- ResultLo and ResultHi hold their values until the next CALC→WLO load.
- Start is ignored while Busy=1. There is no queuing, and the latched operands are unaffected.
- Strobes are mutually exclusive: WrLo and WrHi are never high in the same cycle.

## Timing
- Reset values (output state in the cycle after reset is sampled):
  - MulState=IDLE.
  - Busy, Done, WrLo, WrHi = 0.
  - ResultLo, ResultHi = 0.
  - Accumulator, counter and operand registers = 0.
- Start sampled at edge 0:
  - CALC occupies cycles 1..WIDTH.
  - WLO is cycle WIDTH+1 (cycle 33 for W=32).
  - WHI is cycle WIDTH+2 (long multiplies only).
  - IDLE follows immediately after.
- Busy is high from cycle 1 through the last write state, inclusive. It drops in the first IDLE cycle.
- A new Start is accepted in the first IDLE cycle, so there is no dead cycle between operations.
- Reset mid-operation (any state):
  - Next state is IDLE with all outputs at reset values.
  - No WrLo or WrHi pulse is emitted for the aborted operation.
- Start and reset asserted together: reset wins and the operation is not started.

## Configuration
- MUL_EARLY_TERM_EN
  - Defined: CALC exits to WLO at the end of the first iteration after which the remaining multiplier register is zero. Minimum CALC length is 1 cycle (multiplier = 0 or 1); maximum is WIDTH.
  - Undefined: CALC always runs exactly WIDTH cycles, giving fixed latency.
  - Results are bit-identical in both builds.

## Test plan
- UMULL 0xFFFFFFFF × 0xFFFFFFFF, Start at cycle 0:
  - Done/WrLo at cycle 33 with ResultLo=0x00000001.
  - WrHi at cycle 34 with ResultHi=0xFFFFFFFE.
  - Busy low at cycle 35.
- SMULL −2 (0xFFFFFFFE) × 3 → ResultLo=0xFFFFFFFA, ResultHi=0xFFFFFFFF.
- SMULL 0x80000000 × 0x80000000 → ResultHi=0x40000000, ResultLo=0x00000000.
- MUL 7 × 6:
  - WrLo at cycle 33 with ResultLo=42.
  - WrHi never asserted; IDLE at cycle 34.
- UMULL 5 × 9:
  - Start re-pulsed at cycle 5 with SrcA=SrcB=0xFFFFFFFF, which must be ignored → ResultLo=45, ResultHi=0.
  - Reset pulsed at cycle 10 of a second UMULL → IDLE next cycle, no WrLo/WrHi, Busy=0.
  - A fresh UMULL 5 × 9 then completes normally.
- With MUL_EARLY_TERM_EN, UMULL 0x12345678 × 1 → Done at cycle 2, ResultLo=0x12345678, ResultHi=0.
- Without the macro, the same operation → Done at cycle 33.
